ex_hazard_ctrl: RTL and testbench
=================================

// Module: ex_hazard_ctrl
// PURPOSE
//  Sequencing controller for the execute stage of the 5-stage pipeline.
//  Decides ALU operand forwarding, raises stall_flag for load-use hazards and multi-cycle MUL,
//  and issues flushes after a taken branch.
//  Sits beside the EX stage, reading the IF/ID, ID/EX, EX/DM and DM/WB pipeline-register fields.
// PARAMETERS
//  REG_ADDR_W    5  register address width
//  MUL_LATENCY   4  total EX cycles a MUL occupies (>=2); the extra cycles are stalls
//  FLUSH_CYCLES  1  cycles flush_if_id/flush_id_ex stay high after a taken branch (>=1)
// PORTS
//  clk              in   1  rising-edge clock (the only clock)
//  reset            in   1  asynchronous, active-low reset
//  if_id_rs         in   5  rs address of the instruction in ID
//  if_id_rt         in   5  rt address of the instruction in ID
//  id_ex_rs         in   5  rs address of the instruction in EX
//  id_ex_rt         in   5  rt address of the instruction in EX
//  id_ex_rd         in   5  destination of the instruction in EX, after the reg_dst mux
//  id_ex_mem_read   in   1  instruction in EX is LW
//  id_ex_alu_op     in   2  ALUOp in EX (2'b10 = R-type)
//  id_ex_funct      in   6  funct in EX (6'b000010 = MUL)
//  ex_dm_rd         in   5  destination register in EX/DM
//  ex_dm_reg_write  in   1  EX/DM will write back
//  dm_wb_rd         in   5  destination register in DM/WB
//  dm_wb_reg_write  in   1  DM/WB will write back
//  branch_taken     in   1  EX resolved beq taken this cycle
//  forward_a        out  2  rs operand select: 00 = register file, 10 = EX/DM, 01 = DM/WB
//  forward_b        out  2  rt operand select, same encoding
//  stall_flag       out  1  hold the PC, IF/ID and ID/EX registers
//  bubble_id_ex     out  1  load zeros into the ID/EX control fields
//  flush_if_id      out  1  squash IF/ID
//  flush_id_ex      out  1  squash ID/EX
//  ctrl_state       out  2  FSM state, for debug
// BEHAVIOUR
//  Reset (reset=0, async):
//   - state=IDLE; mul and flush counters = 0.
//   - All registered outputs = 0; the combinational outputs also evaluate to 0 while reset is low.
//  Forwarding (combinational, every cycle, all states):
//   - forward_a = 10 if ex_dm_reg_write && ex_dm_rd!=0 && ex_dm_rd==id_ex_rs;
//     else 01 if dm_wb_reg_write && dm_wb_rd!=0 && dm_wb_rd==id_ex_rs; else 00.
//   - forward_b: same rule using id_ex_rt.
//   - EX/DM has priority over DM/WB. Register 0 is never forwarded.
//  Hazard terms, evaluated in IDLE only:
//   - load_use = id_ex_mem_read && id_ex_rd!=0 && (id_ex_rd==if_id_rs || id_ex_rd==if_id_rt)
//   - is_mul   = id_ex_alu_op==2'b10 && id_ex_funct==6'b000010
//  FSM states: IDLE=0, LOAD_STALL=1, MUL_WAIT=2, FLUSH=3. Transitions are registered.
//   - IDLE, branch_taken -> FLUSH; flush counter = FLUSH_CYCLES-1.
//   - IDLE, else load_use -> LOAD_STALL.
//   - IDLE, else is_mul -> MUL_WAIT; mul counter = MUL_LATENCY-2.
//   - IDLE, else stay in IDLE.
//   - IDLE priority: branch_taken > load_use > is_mul.
//   - LOAD_STALL -> IDLE after exactly 1 cycle.
//   - MUL_WAIT: decrement the counter each cycle; at 0 -> IDLE. Total 1 + (MUL_LATENCY-1) EX cycles.
//   - FLUSH: decrement the counter; at 0 -> IDLE.
//   - branch_taken in LOAD_STALL or MUL_WAIT -> FLUSH immediately. The branch wins; the stall is abandoned.
//  Outputs, registered (visible the cycle after the detecting edge):
//   - stall_flag = 1 in LOAD_STALL and MUL_WAIT.
//   - bubble_id_ex = 1 in LOAD_STALL only.
//   - flush_if_id = flush_id_ex = 1 in FLUSH only.
//   - stall_flag is 0 whenever a flush is high; the two never overlap.
//  Reset asserted mid-stall or mid-flush: return to IDLE at once; the counters clear.
//  Counter width: $clog2(MUL_LATENCY) bits for mul, $clog2(FLUSH_CYCLES+1) bits for flush.
//   - The mul counter never underflows; the load is clamped to MUL_LATENCY-2.
// STRUCTURE
//  Shared package pipe_pkg:
//   - FSM state localparams
//   - forward encodings FWD_RF / FWD_EXDM / FWD_DMWB
//   - ALUOP_RTYPE, FUNCT_ADD / FUNCT_SUB / FUNCT_MUL
//  One sub-module, fwd_unit: the purely combinational forward_a/forward_b logic.
//  The FSM and counters stay in this module.
// TESTING
//  1. reset=0 with random inputs
//     -> all outputs 0 and ctrl_state=0, during and one cycle after release.
//  2. ex_dm_rd=3, ex_dm_reg_write=1, dm_wb_rd=3, dm_wb_reg_write=1, id_ex_rs=3, id_ex_rt=0
//     -> forward_a=10, forward_b=00; same with rd=0 -> forward_a=00.
//  3. id_ex_mem_read=1, id_ex_rd=5, if_id_rt=5
//     -> stall_flag=1 and bubble_id_ex=1 for exactly 1 cycle, then IDLE.
//  4. MUL in EX (alu_op=10, funct=000010) with MUL_LATENCY=4
//     -> stall_flag high for exactly 3 consecutive cycles.
//  5. branch_taken=1 in the same cycle as load_use=1
//     -> FLUSH: flush_if_id=flush_id_ex=1 for 1 cycle, stall_flag=0.
//  6. reset pulsed low in the 2nd MUL_WAIT cycle
//     -> stall_flag drops immediately; after release a new MUL gives a full 3-cycle stall.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: FSM states, forward encodings and opcode fields.
package pipe_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MUL_WAIT   = 2'd2,
    ST_FLUSH      = 2'd3
  } ctrl_state_e;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_EXDM = 2'b10;
  localparam logic [1:0] FWD_DMWB = 2'b01;

  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_MUL   = 6'b000010;

endpackage

// File: rtl/fwd_unit.sv
// Combinational ALU operand forwarding select; EX/DM wins over DM/WB, r0 never forwards.
module fwd_unit
  import pipe_pkg::*;
#(
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic [ADDR_W-1:0] id_ex_rs_i,
  input  logic [ADDR_W-1:0] id_ex_rt_i,
  input  logic [ADDR_W-1:0] ex_dm_rd_i,
  input  logic              ex_dm_reg_write_i,
  input  logic [ADDR_W-1:0] dm_wb_rd_i,
  input  logic              dm_wb_reg_write_i,
  output logic [1:0]        forward_a_o,
  output logic [1:0]        forward_b_o
);

  logic exdm_ok;
  logic dmwb_ok;

  assign exdm_ok = ex_dm_reg_write_i && (ex_dm_rd_i != '0);
  assign dmwb_ok = dm_wb_reg_write_i && (dm_wb_rd_i != '0);

  // Priority select per operand
  always_comb begin
    forward_a_o = FWD_RF;
    forward_b_o = FWD_RF;
    if (exdm_ok && (ex_dm_rd_i == id_ex_rs_i))      forward_a_o = FWD_EXDM;
    else if (dmwb_ok && (dm_wb_rd_i == id_ex_rs_i)) forward_a_o = FWD_DMWB;
    if (exdm_ok && (ex_dm_rd_i == id_ex_rt_i))      forward_b_o = FWD_EXDM;
    else if (dmwb_ok && (dm_wb_rd_i == id_ex_rt_i)) forward_b_o = FWD_DMWB;
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: forwarding, load-use / MUL stalls and branch flushes.
module ex_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_ADDR_W   = pipe_pkg::REG_ADDR_W,
  parameter int unsigned MUL_LATENCY  = 4,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] if_id_rs,
  input  logic [REG_ADDR_W-1:0] if_id_rt,
  input  logic [REG_ADDR_W-1:0] id_ex_rs,
  input  logic [REG_ADDR_W-1:0] id_ex_rt,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic                  id_ex_mem_read,
  input  logic [1:0]            id_ex_alu_op,
  input  logic [5:0]            id_ex_funct,
  input  logic [REG_ADDR_W-1:0] ex_dm_rd,
  input  logic                  ex_dm_reg_write,
  input  logic [REG_ADDR_W-1:0] dm_wb_rd,
  input  logic                  dm_wb_reg_write,
  input  logic                  branch_taken,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic                  stall_flag,
  output logic                  bubble_id_ex,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic [1:0]            ctrl_state
);

  localparam int unsigned MUL_W      = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;
  localparam int unsigned FLUSH_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam int unsigned MUL_LOAD   = (MUL_LATENCY >= 2) ? MUL_LATENCY - 2 : 0;
  localparam int unsigned FLUSH_LOAD = (FLUSH_CYCLES >= 1) ? FLUSH_CYCLES - 1 : 0;

  ctrl_state_e        state_q, state_d;
  logic [MUL_W-1:0]   mul_cnt_q, mul_cnt_d;
  logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
  logic               stall_q, stall_d;
  logic               bubble_q, bubble_d;
  logic               flush_q, flush_d;
  logic               load_use;
  logic               is_mul;
  logic [1:0]         fwd_a_raw;
  logic [1:0]         fwd_b_raw;

  fwd_unit #(.ADDR_W(REG_ADDR_W)) u_fwd (
    .id_ex_rs_i        (id_ex_rs),
    .id_ex_rt_i        (id_ex_rt),
    .ex_dm_rd_i        (ex_dm_rd),
    .ex_dm_reg_write_i (ex_dm_reg_write),
    .dm_wb_rd_i        (dm_wb_rd),
    .dm_wb_reg_write_i (dm_wb_reg_write),
    .forward_a_o       (fwd_a_raw),
    .forward_b_o       (fwd_b_raw)
  );

  // Forward selects read as register file while reset is held
  assign forward_a = reset ? fwd_a_raw : FWD_RF;
  assign forward_b = reset ? fwd_b_raw : FWD_RF;

  assign load_use = id_ex_mem_read && (id_ex_rd != '0) &&
                    ((id_ex_rd == if_id_rs) || (id_ex_rd == if_id_rt));
  assign is_mul   = (id_ex_alu_op == ALUOP_RTYPE) && (id_ex_funct == FUNCT_MUL);

  // Next state, counters and next registered outputs; a branch always preempts a stall
  always_comb begin
    state_d     = state_q;
    mul_cnt_d   = mul_cnt_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (branch_taken) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_W'(FLUSH_LOAD);
        end else if (load_use) begin
          state_d = ST_LOAD_STALL;
        end else if (is_mul) begin
          state_d   = ST_MUL_WAIT;
          mul_cnt_d = MUL_W'(MUL_LOAD);
        end
      end
      ST_LOAD_STALL: begin
        if (branch_taken) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_W'(FLUSH_LOAD);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL_WAIT: begin
        if (branch_taken) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_W'(FLUSH_LOAD);
          mul_cnt_d   = '0;
        end else if (mul_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          mul_cnt_d = mul_cnt_q - MUL_W'(1);
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == '0) state_d = ST_IDLE;
        else                   flush_cnt_d = flush_cnt_q - FLUSH_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    stall_d  = (state_d == ST_LOAD_STALL) || (state_d == ST_MUL_WAIT);
    bubble_d = (state_d == ST_LOAD_STALL);
    flush_d  = (state_d == ST_FLUSH);
  end

  // State, counters and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      mul_cnt_q   <= '0;
      flush_cnt_q <= '0;
      stall_q     <= 1'b0;
      bubble_q    <= 1'b0;
      flush_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mul_cnt_q   <= mul_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      stall_q     <= stall_d;
      bubble_q    <= bubble_d;
      flush_q     <= flush_d;
    end
  end

  assign stall_flag   = stall_q;
  assign bubble_id_ex = bubble_q;
  assign flush_if_id  = flush_q;
  assign flush_id_ex  = flush_q;
  assign ctrl_state   = state_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl with hand-computed expectations.
module tb_ex_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] if_id_rs, if_id_rt, id_ex_rs, id_ex_rt, id_ex_rd;
  logic       id_ex_mem_read;
  logic [1:0] id_ex_alu_op;
  logic [5:0] id_ex_funct;
  logic [4:0] ex_dm_rd, dm_wb_rd;
  logic       ex_dm_reg_write, dm_wb_reg_write, branch_taken;
  logic [1:0] forward_a, forward_b, ctrl_state;
  logic       stall_flag, bubble_id_ex, flush_if_id, flush_id_ex;

  int checks = 0;
  int errors = 0;

  ex_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_alu_op(id_ex_alu_op), .id_ex_funct(id_ex_funct),
    .ex_dm_rd(ex_dm_rd), .ex_dm_reg_write(ex_dm_reg_write),
    .dm_wb_rd(dm_wb_rd), .dm_wb_reg_write(dm_wb_reg_write),
    .branch_taken(branch_taken),
    .forward_a(forward_a), .forward_b(forward_b),
    .stall_flag(stall_flag), .bubble_id_ex(bubble_id_ex),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .ctrl_state(ctrl_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_id_rs = '0; if_id_rt = '0; id_ex_rs = '0; id_ex_rt = '0; id_ex_rd = '0;
    id_ex_mem_read = 1'b0; id_ex_alu_op = '0; id_ex_funct = '0;
    ex_dm_rd = '0; ex_dm_reg_write = 1'b0; dm_wb_rd = '0; dm_wb_reg_write = 1'b0;
    branch_taken = 1'b0;
  endtask

  // Checks stall/bubble/flush/state together
  task automatic check_ctrl(input string tag, input logic st, input logic bu,
                            input logic fl, input logic [1:0] cs);
    check({tag, ".stall"},  32'(stall_flag),   32'(st));
    check({tag, ".bubble"}, 32'(bubble_id_ex), 32'(bu));
    check({tag, ".fl_ifid"}, 32'(flush_if_id), 32'(fl));
    check({tag, ".fl_idex"}, 32'(flush_id_ex), 32'(fl));
    check({tag, ".state"},  32'(ctrl_state),   32'(cs));
  endtask

  // Launches a MUL into EX for one detecting edge
  task automatic issue_mul();
    id_ex_alu_op = 2'b10;
    id_ex_funct  = 6'b000010;
    tick();
    clear_inputs();
  endtask

  // Counts consecutive stall cycles from now, bounded
  task automatic count_stall(output int n);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (stall_flag) n++;
      else break;
      tick();
    end
  endtask

  int n;

  initial begin
    clear_inputs();
    reset = 1'b0;

    // 1: reset with random inputs
    for (int i = 0; i < 4; i++) begin
      if_id_rs = 5'($urandom); if_id_rt = 5'($urandom);
      id_ex_rs = 5'($urandom); id_ex_rt = 5'($urandom); id_ex_rd = 5'($urandom);
      id_ex_mem_read = 1'($urandom); id_ex_alu_op = 2'($urandom); id_ex_funct = 6'($urandom);
      ex_dm_rd = 5'($urandom); ex_dm_reg_write = 1'($urandom);
      dm_wb_rd = 5'($urandom); dm_wb_reg_write = 1'($urandom);
      branch_taken = 1'($urandom);
      tick();
      check("rst.fwd_a", 32'(forward_a), 32'd0);
      check("rst.fwd_b", 32'(forward_b), 32'd0);
      check_ctrl("rst", 1'b0, 1'b0, 1'b0, 2'd0);
    end
    clear_inputs();
    reset = 1'b1;
    tick();
    check("rel.fwd_a", 32'(forward_a), 32'd0);
    check_ctrl("rel", 1'b0, 1'b0, 1'b0, 2'd0);

    // 2: forwarding
    ex_dm_rd = 5'd3; ex_dm_reg_write = 1'b1; dm_wb_rd = 5'd3; dm_wb_reg_write = 1'b1;
    id_ex_rs = 5'd3; id_ex_rt = 5'd0;
    #1;
    check("fwd.prio_a", 32'(forward_a), 32'h2);
    check("fwd.rt0_b",  32'(forward_b), 32'h0);
    ex_dm_rd = 5'd0; dm_wb_rd = 5'd0; id_ex_rs = 5'd0;
    #1;
    check("fwd.r0_a", 32'(forward_a), 32'h0);
    ex_dm_rd = 5'd7; dm_wb_rd = 5'd3; id_ex_rs = 5'd3; id_ex_rt = 5'd7;
    #1;
    check("fwd.dmwb_a", 32'(forward_a), 32'h1);
    check("fwd.exdm_b", 32'(forward_b), 32'h2);
    ex_dm_reg_write = 1'b0; dm_wb_reg_write = 1'b0;
    #1;
    check("fwd.nowr_a", 32'(forward_a), 32'h0);
    check("fwd.nowr_b", 32'(forward_b), 32'h0);
    tick();
    check("fwd.state", 32'(ctrl_state), 32'd0);
    clear_inputs();

    // 3: load-use stall on rt, then non-hazard load to r0
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd5; if_id_rt = 5'd5;
    tick();
    clear_inputs();
    check_ctrl("lu.c1", 1'b1, 1'b1, 1'b0, 2'd1);
    tick();
    check_ctrl("lu.c2", 1'b0, 1'b0, 1'b0, 2'd0);
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd0; if_id_rs = 5'd0;
    tick();
    clear_inputs();
    check_ctrl("lu.r0", 1'b0, 1'b0, 1'b0, 2'd0);

    // ADD in EX must not stall
    id_ex_alu_op = 2'b10; id_ex_funct = 6'b100000;
    tick();
    clear_inputs();
    check_ctrl("add", 1'b0, 1'b0, 1'b0, 2'd0);

    // 4: MUL stalls exactly 3 cycles
    issue_mul();
    check_ctrl("mul.c1", 1'b1, 1'b0, 1'b0, 2'd2);
    count_stall(n);
    check("mul.len", 32'(n), 32'd3);
    check_ctrl("mul.end", 1'b0, 1'b0, 1'b0, 2'd0);

    // 5: branch beats load-use
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd5; if_id_rt = 5'd5; branch_taken = 1'b1;
    tick();
    clear_inputs();
    check_ctrl("br.c1", 1'b0, 1'b0, 1'b1, 2'd3);
    tick();
    check_ctrl("br.c2", 1'b0, 1'b0, 1'b0, 2'd0);

    // branch during MUL_WAIT abandons the stall
    issue_mul();
    branch_taken = 1'b1;
    tick();
    clear_inputs();
    check_ctrl("brmul.c1", 1'b0, 1'b0, 1'b1, 2'd3);
    tick();
    check_ctrl("brmul.c2", 1'b0, 1'b0, 1'b0, 2'd0);

    // 6: reset in the 2nd MUL_WAIT cycle, then a full stall again
    issue_mul();
    tick();
    check("mrst.pre", 32'(stall_flag), 32'd1);
    reset = 1'b0;
    #1;
    check_ctrl("mrst.now", 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    reset = 1'b1;
    tick();
    check_ctrl("mrst.rel", 1'b0, 1'b0, 1'b0, 2'd0);
    issue_mul();
    count_stall(n);
    check("mrst.len", 32'(n), 32'd3);
    check_ctrl("mrst.end", 1'b0, 1'b0, 1'b0, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
